core_pipe_ctrl: RTL and testbench
=================================

# core_pipe_ctrl

Parametrised pipeline control unit for the RISC-V core; next generation of the single-source core controller. Arbitrates redirects from several execute-side jump sources plus the exception/interrupt controller. Sequences a configurable-length pipeline flush, runs an explicit WFI sleep state, and gates core stalls. Maintains a writable instructions-retired counter for the CSR unit (minstret backing).

## Interface
Parameters:
- STALL_REQ_NUM, 1, number of external stall request lines.
- JUMP_SRC_NUM, 2, number of execute-side jump sources; index 0 has the highest priority.
- FLUSH_CYCLES, 2, bubble cycles inserted after a redirect; legal range 1..15.
- CNT_W, 64, retired-instruction counter width; legal range 32..64.

Ports (one clock; reset is asynchronous and active-high):
- clk  in  1  core clock.
- rst  in  1  asynchronous active-high reset.
- stall_req  in  STALL_REQ_NUM  external stall requests, OR-combined.
- jump_en_src  in  JUMP_SRC_NUM  per-source jump request.
- jump_addr_src  in  32*JUMP_SRC_NUM  per-source target; source i occupies bits [32i+31:32i].
- wait_for_interrupt  in  1  WFI instruction in execute.
- any_interrupt_come  in  1  any pending interrupt, whether enabled or not (WFI wake).
- valid_interrupt_request  in  1  interrupt being taken this cycle.
- exception_occurred  in  1  exception/trap redirect this cycle.
- exception_jump_addr  in  32  trap target.
- retire_cnt_inhibit  in  1  freeze counter increments.
- retire_cnt_wr_en  in  1  CSR write strobe.
- retire_cnt_wr_data  in  CNT_W  CSR write value.
- jump_addr  out  32  selected redirect target.
- jump_en  out  1  redirect this cycle.
- hold_flag  out  1  redirect or interrupt taken; flushes fetch/decode.
- stall_n  out  1  active-low core stall.
- clearing_pipeline  out  1  current execute slot is a flush bubble.
- instruction_retire  out  1  an instruction completes this cycle.
- retire_cnt  out  CNT_W  retired-instruction count.
- ctrl_state  out  2  FSM state: RUN=0, FLUSH=1, WFI=2.

## Operation
- **Redirect mux (combinational):**
  - exception_occurred has top priority: jump_addr = exception_jump_addr.
  - Otherwise the lowest-index asserted jump_en_src selects jump_addr.
  - With nothing asserted, jump_addr = source 0 address (don't-care).
  - jump_en = exception_occurred | (|jump_en_src).
  - hold_flag = jump_en | valid_interrupt_request.
- **FSM, evaluated at each posedge:**
  - **RUN:**
    - hold_flag → FLUSH, nop_cnt ← FLUSH_CYCLES.
    - Else wait_for_interrupt & !any_interrupt_come → WFI.
    - Else stay in RUN.
  - **FLUSH:**
    - hold_flag → reload nop_cnt ← FLUSH_CYCLES, stay in FLUSH.
    - Else nop_cnt ← nop_cnt−1.
    - When nop_cnt==1 and no hold_flag → RUN with nop_cnt ← 0.
    - Decrement continues regardless of stall_req.
  - **WFI:**
    - hold_flag → FLUSH (reload).
    - Else any_interrupt_come → RUN.
    - Else stay in WFI.
  - State encoding 3 is illegal; it recovers to RUN on the next edge.
- **Outputs:**
  - clearing_pipeline = (nop_cnt != 0); width of nop_cnt = $clog2(FLUSH_CYCLES+1).
  - waiting = !any_interrupt_come & ((ctrl_state==WFI) | (ctrl_state==RUN & wait_for_interrupt)).
  - stall_n = !(|stall_req | waiting).
  - instruction_retire = !(clearing_pipeline | exception_occurred) & (jump_en | stall_n).
- **Retire counter:**
  - retire_cnt_wr_en loads retire_cnt_wr_data and has priority over any increment in the same cycle.
  - Otherwise retire_cnt increments by 1 when instruction_retire & !retire_cnt_inhibit.
  - Wraps modulo 2^CNT_W.

## Timing
- Reset values (async assert, deassert synchronous to clk):
  - ctrl_state=RUN, nop_cnt=0, retire_cnt=0.
  - Hence clearing_pipeline=0, and stall_n=1 if no inputs are asserted.
- jump_addr, jump_en, hold_flag, stall_n and instruction_retire are combinational, zero latency.
- A redirect in cycle N gives clearing_pipeline=1 in cycles N+1..N+FLUSH_CYCLES and 0 in N+FLUSH_CYCLES+1.
- A back-to-back redirect during FLUSH restarts the full FLUSH_CYCLES window from that edge.
- WFI entry:
  - stall_n drops in the same cycle wait_for_interrupt rises.
  - ctrl_state=WFI from the next cycle.
- WFI wake:
  - any_interrupt_come releases stall_n combinationally in the same cycle.
  - The FSM is in RUN the next cycle.
- Simultaneous exception and jump_en_src: the exception address wins and instruction_retire=0.
- Reset mid-FLUSH or mid-WFI: immediate return to RUN and nop_cnt=0; the counter clears.

## Test plan
- Reset, then JUMP_SRC_NUM=2, FLUSH_CYCLES=3.
  - Stimulus: jump_en_src=2'b11, addr0=0x100, addr1=0x200.
  - Required: jump_addr=0x100, hold_flag=1, then clearing_pipeline=1 for exactly 3 cycles.
- Exception priority.
  - Stimulus: exception_occurred=1 with jump_en_src[1]=1, exception_jump_addr=0x8000_0004.
  - Required: jump_addr=0x8000_0004, instruction_retire=0, retire_cnt unchanged.
- Flush restart.
  - Stimulus: second jump one cycle after the first.
  - Required: clearing_pipeline stays high for 1+FLUSH_CYCLES cycles total; ctrl_state back to 0 afterwards.
- WFI sleep and wake.
  - Stimulus: hold wait_for_interrupt=1 for 10 cycles, then any_interrupt_come=1.
  - Required: stall_n=0 and ctrl_state=2 during the sleep; stall_n=1 in the wake cycle; ctrl_state=0 next cycle.
  - Variant: valid_interrupt_request in WFI → ctrl_state=1.
- Retire counter, CNT_W=32.
  - Stimulus: write 0xFFFF_FFFE, then retire 3 instructions, with retire_cnt_inhibit=1 for one of them.
  - Required: sequence 0xFFFF_FFFF, hold, 0x0000_0000.
  - Required: a simultaneous write and retire loads the written value.
- Stall gating.
  - Stimulus: stall_req[0]=1 with no jump.
  - Required: stall_n=0, instruction_retire=0, retire_cnt constant.
  - Stimulus: jump during the stall.
  - Required: instruction_retire=1.

Source files
------------

// File: rtl/core_pipe_ctrl.sv
// Pipeline control unit: redirect arbitration, flush sequencing, WFI sleep,
// stall gating and the instructions-retired counter backing minstret.
module core_pipe_ctrl #(
  parameter int unsigned STALL_REQ_NUM = 1,
  parameter int unsigned JUMP_SRC_NUM  = 2,
  parameter int unsigned FLUSH_CYCLES  = 2,
  parameter int unsigned CNT_W         = 64
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [STALL_REQ_NUM-1:0]   stall_req,
  input  logic [JUMP_SRC_NUM-1:0]    jump_en_src,
  input  logic [32*JUMP_SRC_NUM-1:0] jump_addr_src,
  input  logic                       wait_for_interrupt,
  input  logic                       any_interrupt_come,
  input  logic                       valid_interrupt_request,
  input  logic                       exception_occurred,
  input  logic [31:0]                exception_jump_addr,
  input  logic                       retire_cnt_inhibit,
  input  logic                       retire_cnt_wr_en,
  input  logic [CNT_W-1:0]           retire_cnt_wr_data,
  output logic [31:0]                jump_addr,
  output logic                       jump_en,
  output logic                       hold_flag,
  output logic                       stall_n,
  output logic                       clearing_pipeline,
  output logic                       instruction_retire,
  output logic [CNT_W-1:0]           retire_cnt,
  output logic [1:0]                 ctrl_state
);

  localparam int unsigned NOP_W = $clog2(FLUSH_CYCLES + 1);
  localparam logic [NOP_W-1:0] NOP_LOAD = NOP_W'(FLUSH_CYCLES);
  localparam logic [NOP_W-1:0] NOP_ONE  = NOP_W'(1);

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    FLUSH = 2'd1,
    WFI   = 2'd2
  } state_t;

  state_t           state;
  state_t           state_next;
  logic [NOP_W-1:0] nop_cnt;
  logic [NOP_W-1:0] nop_next;
  logic [31:0]      src_addr;
  logic             src_found;
  logic             waiting;

  // Lowest-index asserted source wins; source 0 is the idle default.
  always_comb begin
    src_addr  = jump_addr_src[31:0];
    src_found = 1'b0;
    for (int unsigned i = 0; i < JUMP_SRC_NUM; i++) begin
      if (!src_found && jump_en_src[i]) begin
        src_addr  = jump_addr_src[32*i +: 32];
        src_found = 1'b1;
      end
    end
  end

  assign jump_addr = exception_occurred ? exception_jump_addr : src_addr;
  assign jump_en   = exception_occurred | (|jump_en_src);
  assign hold_flag = jump_en | valid_interrupt_request;

  assign clearing_pipeline  = (nop_cnt != '0);
  assign waiting            = !any_interrupt_come &
                              ((state == WFI) | ((state == RUN) & wait_for_interrupt));
  assign stall_n            = !((|stall_req) | waiting);
  assign instruction_retire = !(clearing_pipeline | exception_occurred) & (jump_en | stall_n);
  assign ctrl_state         = state;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= RUN;
      nop_cnt <= '0;
    end else begin
      state   <= state_next;
      nop_cnt <= nop_next;
    end
  end

  always_comb begin
    state_next = state;
    nop_next   = nop_cnt;
    case (state)
      RUN: begin
        nop_next = '0;
        if (hold_flag) begin
          state_next = FLUSH;
          nop_next   = NOP_LOAD;
        end else if (wait_for_interrupt && !any_interrupt_come) begin
          state_next = WFI;
        end
      end
      FLUSH: begin
        // A new redirect restarts the whole bubble window; stalls do not pause it.
        if (hold_flag) begin
          nop_next = NOP_LOAD;
        end else if (nop_cnt <= NOP_ONE) begin
          state_next = RUN;
          nop_next   = '0;
        end else begin
          nop_next = nop_cnt - NOP_ONE;
        end
      end
      WFI: begin
        if (hold_flag) begin
          state_next = FLUSH;
          nop_next   = NOP_LOAD;
        end else if (any_interrupt_come) begin
          state_next = RUN;
          nop_next   = '0;
        end
      end
      default: begin
        state_next = RUN;
        nop_next   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      retire_cnt <= '0;
    end else if (retire_cnt_wr_en) begin
      retire_cnt <= retire_cnt_wr_data;
    end else if (instruction_retire && !retire_cnt_inhibit) begin
      retire_cnt <= retire_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_core_pipe_ctrl.sv
// Bench for core_pipe_ctrl: combinational vector table plus multi-cycle
// sequences, all checked through an expectation queue drained at negedge.
module tb_core_pipe_ctrl;

  localparam int unsigned JN = 2;
  localparam int unsigned FC = 3;
  localparam int unsigned CW = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic [0:0]    stall_req;
  logic [JN-1:0] jump_en_src;
  logic [63:0]   jump_addr_src;
  logic          wait_for_interrupt, any_interrupt_come, valid_interrupt_request;
  logic          exception_occurred;
  logic [31:0]   exception_jump_addr;
  logic          retire_cnt_inhibit, retire_cnt_wr_en;
  logic [CW-1:0] retire_cnt_wr_data;
  logic [31:0]   jump_addr;
  logic          jump_en, hold_flag, stall_n, clearing_pipeline, instruction_retire;
  logic [CW-1:0] retire_cnt;
  logic [1:0]    ctrl_state;

  core_pipe_ctrl #(
    .STALL_REQ_NUM(1),
    .JUMP_SRC_NUM (JN),
    .FLUSH_CYCLES (FC),
    .CNT_W        (CW)
  ) dut (
    .clk                    (clk),
    .rst                    (rst),
    .stall_req              (stall_req),
    .jump_en_src            (jump_en_src),
    .jump_addr_src          (jump_addr_src),
    .wait_for_interrupt     (wait_for_interrupt),
    .any_interrupt_come     (any_interrupt_come),
    .valid_interrupt_request(valid_interrupt_request),
    .exception_occurred     (exception_occurred),
    .exception_jump_addr    (exception_jump_addr),
    .retire_cnt_inhibit     (retire_cnt_inhibit),
    .retire_cnt_wr_en       (retire_cnt_wr_en),
    .retire_cnt_wr_data     (retire_cnt_wr_data),
    .jump_addr              (jump_addr),
    .jump_en                (jump_en),
    .hold_flag              (hold_flag),
    .stall_n                (stall_n),
    .clearing_pipeline      (clearing_pipeline),
    .instruction_retire     (instruction_retire),
    .retire_cnt             (retire_cnt),
    .ctrl_state             (ctrl_state)
  );

  always #5 clk = ~clk;

  typedef enum {S_ADDR, S_JEN, S_HOLD, S_STALLN, S_CLR, S_RET, S_CNT, S_STATE} sig_e;
  typedef struct {
    sig_e        sig;
    logic [63:0] val;
    string       name;
  } exp_t;

  typedef struct {
    logic          stall;
    logic [JN-1:0] jen;
    logic          wfi;
    logic          aic;
    logic          vir;
    logic          exc;
    logic [31:0]   eaddr;
    logic [31:0]   x_addr;
    logic          x_jen;
    logic          x_hold;
    logic          x_stalln;
    logic          x_ret;
  } vec_t;

  exp_t sbq[$];
  vec_t vecs[12];
  int   checks = 0;
  int   errors = 0;

  function automatic logic [63:0] read_sig(input sig_e s);
    case (s)
      S_ADDR:   return {32'd0, jump_addr};
      S_JEN:    return {63'd0, jump_en};
      S_HOLD:   return {63'd0, hold_flag};
      S_STALLN: return {63'd0, stall_n};
      S_CLR:    return {63'd0, clearing_pipeline};
      S_RET:    return {63'd0, instruction_retire};
      S_CNT:    return {32'd0, retire_cnt};
      default:  return {62'd0, ctrl_state};
    endcase
  endfunction

  task automatic expect_v(input sig_e s, input logic [63:0] v, input string n);
    exp_t e;
    e.sig  = s;
    e.val  = v;
    e.name = n;
    sbq.push_back(e);
  endtask

  task automatic drain();
    exp_t        e;
    logic [63:0] act;
    while (sbq.size() > 0) begin
      e   = sbq.pop_front();
      act = read_sig(e.sig);
      checks++;
      if (act !== e.val) begin
        errors++;
        $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", e.name, act, e.val, $time);
      end
    end
  endtask

  task automatic step();
    @(negedge clk);
    drain();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    stall_req               = '0;
    jump_en_src             = '0;
    wait_for_interrupt      = 1'b0;
    any_interrupt_come      = 1'b0;
    valid_interrupt_request = 1'b0;
    exception_occurred      = 1'b0;
    exception_jump_addr     = 32'h0;
    retire_cnt_inhibit      = 1'b1;
    retire_cnt_wr_en        = 1'b0;
    retire_cnt_wr_data      = '0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    jump_addr_src = {32'h0000_0200, 32'h0000_0100};
    clear_inputs();
    rst = 1'b1;

    //          stall jen    wfi  aic  vir  exc  eaddr          addr           jen  hold stn  ret
    vecs[0]  = '{1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0,         32'h100,       1'b0, 1'b0, 1'b1, 1'b1};
    vecs[1]  = '{1'b0, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0,         32'h100,       1'b1, 1'b1, 1'b1, 1'b1};
    vecs[2]  = '{1'b0, 2'b10, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0,         32'h200,       1'b1, 1'b1, 1'b1, 1'b1};
    vecs[3]  = '{1'b0, 2'b01, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0,         32'h100,       1'b1, 1'b1, 1'b1, 1'b1};
    vecs[4]  = '{1'b0, 2'b10, 1'b0, 1'b0, 1'b0, 1'b1, 32'h8000_0004, 32'h8000_0004, 1'b1, 1'b1, 1'b1, 1'b0};
    vecs[5]  = '{1'b0, 2'b00, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0,         32'h100,       1'b0, 1'b1, 1'b1, 1'b1};
    vecs[6]  = '{1'b1, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0,         32'h100,       1'b0, 1'b0, 1'b0, 1'b0};
    vecs[7]  = '{1'b1, 2'b01, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0,         32'h100,       1'b1, 1'b1, 1'b0, 1'b1};
    vecs[8]  = '{1'b0, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0,         32'h100,       1'b0, 1'b0, 1'b0, 1'b0};
    vecs[9]  = '{1'b0, 2'b00, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0,         32'h100,       1'b0, 1'b0, 1'b1, 1'b1};
    vecs[10] = '{1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1, 32'h1234_5678, 32'h1234_5678, 1'b1, 1'b1, 1'b1, 1'b0};
    vecs[11] = '{1'b0, 2'b10, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0,         32'h200,       1'b1, 1'b1, 1'b0, 1'b1};

    // Reset state
    expect_v(S_STATE, 0, "reset_state");
    expect_v(S_CLR, 0, "reset_clr");
    expect_v(S_STALLN, 1, "reset_stalln");
    expect_v(S_CNT, 0, "reset_cnt");
    step();

    // Held in reset so every vector sees RUN with an empty flush counter.
    for (int i = 0; i < 12; i++) begin
      stall_req[0]            = vecs[i].stall;
      jump_en_src             = vecs[i].jen;
      wait_for_interrupt      = vecs[i].wfi;
      any_interrupt_come      = vecs[i].aic;
      valid_interrupt_request = vecs[i].vir;
      exception_occurred      = vecs[i].exc;
      exception_jump_addr     = vecs[i].eaddr;
      expect_v(S_ADDR, {32'd0, vecs[i].x_addr}, $sformatf("vec%0d_addr", i));
      expect_v(S_JEN, {63'd0, vecs[i].x_jen}, $sformatf("vec%0d_jen", i));
      expect_v(S_HOLD, {63'd0, vecs[i].x_hold}, $sformatf("vec%0d_hold", i));
      expect_v(S_STALLN, {63'd0, vecs[i].x_stalln}, $sformatf("vec%0d_stalln", i));
      expect_v(S_RET, {63'd0, vecs[i].x_ret}, $sformatf("vec%0d_ret", i));
      step();
    end
    clear_inputs();
    rst = 1'b0;
    expect_v(S_STATE, 0, "post_reset_state");
    expect_v(S_CNT, 0, "post_reset_cnt");
    step();

    // Flush window of exactly FC cycles
    jump_en_src = 2'b11;
    expect_v(S_ADDR, 32'h100, "flush_addr");
    expect_v(S_HOLD, 1, "flush_hold");
    expect_v(S_CLR, 0, "flush_clr_n");
    step();
    clear_inputs();
    expect_v(S_STATE, 1, "flush_state");
    for (int i = 0; i < int'(FC); i++) begin
      expect_v(S_CLR, 1, $sformatf("flush_clr_%0d", i));
      step();
    end
    expect_v(S_CLR, 0, "flush_clr_end");
    expect_v(S_STATE, 0, "flush_state_end");
    step();

    // Back-to-back redirect restarts the window
    jump_en_src = 2'b01;
    step();
    jump_en_src = 2'b10;
    expect_v(S_CLR, 1, "restart_clr_0");
    expect_v(S_ADDR, 32'h200, "restart_addr");
    step();
    clear_inputs();
    for (int i = 1; i <= int'(FC); i++) begin
      expect_v(S_CLR, 1, $sformatf("restart_clr_%0d", i));
      step();
    end
    expect_v(S_CLR, 0, "restart_clr_end");
    expect_v(S_STATE, 0, "restart_state_end");
    step();

    // Exception wins over jump source and does not retire
    retire_cnt_wr_en   = 1'b1;
    retire_cnt_wr_data = 32'h0000_1000;
    step();
    retire_cnt_wr_en    = 1'b0;
    retire_cnt_inhibit  = 1'b0;
    exception_occurred  = 1'b1;
    jump_en_src         = 2'b10;
    exception_jump_addr = 32'h8000_0004;
    expect_v(S_ADDR, 32'h8000_0004, "exc_addr");
    expect_v(S_RET, 0, "exc_ret");
    expect_v(S_CNT, 32'h1000, "exc_cnt_before");
    step();
    clear_inputs();
    expect_v(S_CNT, 32'h1000, "exc_cnt_after");
    expect_v(S_CLR, 1, "exc_clr");
    step();
    step();
    step();
    expect_v(S_CLR, 0, "exc_clr_end");
    expect_v(S_STATE, 0, "exc_state_end");
    step();

    // WFI sleep and wake
    wait_for_interrupt = 1'b1;
    expect_v(S_STALLN, 0, "wfi_entry_stalln");
    expect_v(S_STATE, 0, "wfi_entry_state");
    expect_v(S_RET, 0, "wfi_entry_ret");
    step();
    for (int i = 1; i < 10; i++) begin
      expect_v(S_STALLN, 0, $sformatf("wfi_sleep_stalln_%0d", i));
      expect_v(S_STATE, 2, $sformatf("wfi_sleep_state_%0d", i));
      step();
    end
    any_interrupt_come = 1'b1;
    expect_v(S_STALLN, 1, "wfi_wake_stalln");
    expect_v(S_STATE, 2, "wfi_wake_state");
    expect_v(S_RET, 1, "wfi_wake_ret");
    step();
    clear_inputs();
    expect_v(S_STATE, 0, "wfi_after_state");
    expect_v(S_STALLN, 1, "wfi_after_stalln");
    step();

    // Interrupt taken while asleep goes to FLUSH
    wait_for_interrupt = 1'b1;
    step();
    wait_for_interrupt = 1'b0;
    expect_v(S_STATE, 2, "wfi_irq_sleep_state");
    expect_v(S_STALLN, 0, "wfi_irq_sleep_stalln");
    step();
    valid_interrupt_request = 1'b1;
    any_interrupt_come      = 1'b1;
    expect_v(S_HOLD, 1, "wfi_irq_hold");
    step();
    clear_inputs();
    expect_v(S_STATE, 1, "wfi_irq_state");
    expect_v(S_CLR, 1, "wfi_irq_clr");
    step();
    step();
    step();
    expect_v(S_CLR, 0, "wfi_irq_clr_end");
    expect_v(S_STATE, 0, "wfi_irq_state_end");
    step();

    // Counter write, wrap and inhibit
    retire_cnt_wr_en   = 1'b1;
    retire_cnt_wr_data = 32'hFFFF_FFFE;
    step();
    retire_cnt_wr_en   = 1'b0;
    retire_cnt_inhibit = 1'b0;
    expect_v(S_CNT, 32'hFFFF_FFFE, "cnt_written");
    expect_v(S_RET, 1, "cnt_ret");
    step();
    retire_cnt_inhibit = 1'b1;
    expect_v(S_CNT, 32'hFFFF_FFFF, "cnt_inc_1");
    step();
    retire_cnt_inhibit = 1'b0;
    expect_v(S_CNT, 32'hFFFF_FFFF, "cnt_inhibit_hold");
    step();
    retire_cnt_inhibit = 1'b1;
    expect_v(S_CNT, 32'h0, "cnt_wrap");
    step();
    retire_cnt_inhibit = 1'b0;
    retire_cnt_wr_en   = 1'b1;
    retire_cnt_wr_data = 32'h0000_1234;
    expect_v(S_RET, 1, "cnt_wr_ret");
    step();
    clear_inputs();
    expect_v(S_CNT, 32'h1234, "cnt_wr_priority");
    step();

    // Stall gating
    retire_cnt_wr_en   = 1'b1;
    retire_cnt_wr_data = 32'h50;
    step();
    retire_cnt_wr_en   = 1'b0;
    retire_cnt_inhibit = 1'b0;
    stall_req          = 1'b1;
    for (int i = 0; i < 3; i++) begin
      expect_v(S_STALLN, 0, $sformatf("stall_stalln_%0d", i));
      expect_v(S_RET, 0, $sformatf("stall_ret_%0d", i));
      expect_v(S_CNT, 32'h50, $sformatf("stall_cnt_%0d", i));
      step();
    end
    jump_en_src = 2'b01;
    expect_v(S_RET, 1, "stall_jump_ret");
    expect_v(S_STALLN, 0, "stall_jump_stalln");
    step();
    clear_inputs();
    expect_v(S_CNT, 32'h51, "stall_jump_cnt");
    expect_v(S_STATE, 1, "stall_jump_state");
    step();
    step();
    step();
    expect_v(S_CLR, 0, "stall_clr_end");
    step();

    // Asynchronous reset in the middle of a flush
    jump_en_src = 2'b01;
    step();
    clear_inputs();
    #2;
    rst = 1'b1;
    #1;
    expect_v(S_STATE, 0, "async_rst_state");
    expect_v(S_CLR, 0, "async_rst_clr");
    expect_v(S_CNT, 0, "async_rst_cnt");
    drain();
    @(posedge clk);
    #1;
    rst = 1'b0;
    expect_v(S_STATE, 0, "post_async_state");
    expect_v(S_CLR, 0, "post_async_clr");
    step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
